board_io_ctrl: RTL

- Parametrised board I/O front end for the DE2 CPU top level.
- Synchronises the slide switches and debounces the push keys into levels and single-cycle press pulses.
- Latches a CPU output value, with a key-toggled freeze mode, and drives NUM_DIGITS registered active-low seven-segment displays with optional leading-zero blanking.
- Replaces the fixed 8-digit combinational display path with a width/digit/key-count-generic sequential block.

---
 rtl/board_io_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O front end: switch sync, key debounce/press pulses, freezable value latch, 7-seg drive.
// Latency: sw 2 cycles, key 2+DEBOUNCE_CYCLES cycles, value->hex 2 cycles; no flow control, no backpressure.
module board_io_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int VAL_W           = 32,
  parameter int SW_W            = 18,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLD_KEY        = 1,
  parameter int BLANK_LZ        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_KEYS-1:0]     key_n,
  input  logic [SW_W-1:0]         sw,
  input  logic [VAL_W-1:0]        value,
  output logic [SW_W-1:0]         sw_sync,
  output logic [NUM_KEYS-1:0]     key_level,
  output logic [NUM_KEYS-1:0]     key_press,
  output logic                    frozen,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int LAT_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]     sw_meta;
  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] key_level_d;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic [LAT_W-1:0]    latch;
  logic [7*NUM_DIGITS-1:0] hex_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Two-flop synchronisers; keys are inverted so the sample is 1 = pressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '0;
      key_s    <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      key_meta <= ~key_n;
      key_s    <= key_meta;
    end
  end

  // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level <= '0;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_s[k] == key_level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_LAST) begin
          key_level[k] <= key_s[k];
          db_cnt[k]    <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level_d <= '0;
      key_press   <= '0;
    end else begin
      key_level_d <= key_level;
      key_press   <= key_level & ~key_level_d;
    end
  end

  // The load decision uses the pre-edge frozen, so the freezing edge still captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frozen <= 1'b0;
      latch  <= '0;
    end else begin
      if (key_press[HOLD_KEY]) frozen <= ~frozen;
      if (!frozen) latch <= LAT_W'(value);
    end
  end

  always_comb begin
    logic above_nz;
    hex_nxt  = '1;
    above_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above_nz = above_nz | (latch[4*i +: 4] != 4'h0);
      if (BLANK_LZ == 0 || i == 0 || above_nz)
        hex_nxt[7*i +: 7] = seg7(latch[4*i +: 4]);
      else
        hex_nxt[7*i +: 7] = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hex <= '1;
    else      hex <= hex_nxt;
  end

endmodule
